hazard_control: RTL and testbench
=================================

Name: hazard_control

Overview:
- Sits on the execute side of the ID/EX pipeline register and reads that register's EX-stage outputs plus the IF/ID source-register fields.
- Decides stall, bubble and flush for the 5-stage pipeline. It drives the write enables of the PC and the IF/ID register, and the flush inputs of the IF/ID and ID/EX registers.
- Covers load-use hazards (1..N stall cycles, sequenced by a counter FSM) and taken branch / Jr redirects resolved in EX.

Parameters:
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1 with forwarding, 2 without); legal range 1..7.
- CNT_W, 32, width of the statistics counters (used only with the optional feature).

Ports:
- Clk  in  1  pipeline clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- MemReadEX  in  2  ID/EX MemRead field; nonzero means the EX instruction is a load.
- RegWriteEX  in  1  ID/EX RegWrite.
- RegDstEX  in  1  ID/EX RegDst; 1 selects RegDst2EX (rd), 0 selects RegDst1EX (rt).
- RegDst1EX  in  5  ID/EX rt field.
- RegDst2EX  in  5  ID/EX rd field.
- RsID  in  5  IF/ID instruction[25:21].
- RtID  in  5  IF/ID instruction[20:16].
- UsesRtID  in  1  the ID instruction reads rt (R-type, branch, store).
- BranchTakenEX  in  1  branch condition true in EX.
- JrEX  in  1  ID/EX Jr.
- PCWrite  out  1  PC load enable.
- IFIDWrite  out  1  IF/ID load enable.
- IFIDFlush  out  1  IF/ID load-zero (NOP).
- IDEXFlush  out  1  ID/EX clears all control bits to 0 (bubble).
- StallCount  out  CNT_W  stall cycles; present only with HAZARD_STATS_EN.
- FlushCount  out  CNT_W  redirect events; present only with HAZARD_STATS_EN.

Behaviour:
- Dest register: DestEX = RegDstEX ? RegDst2EX : RegDst1EX.
- Hazard condition: LoadHit = (MemReadEX != 0) & RegWriteEX & (DestEX != 0) & (DestEX == RsID | (UsesRtID & DestEX == RtID)).
- Redirect: Redirect = BranchTakenEX | JrEX.
- FSM states: RUN and STALL, plus a 3-bit down-counter cnt.
- RUN, default outputs: PCWrite=1, IFIDWrite=1, IFIDFlush=0, IDEXFlush=0.
- RUN, priority 1 — Redirect:
  - Outputs: IFIDFlush=1, IDEXFlush=1, PCWrite=1 (PC takes target), IFIDWrite=1.
  - Next state: RUN.
  - LoadHit in the same cycle is ignored, because the younger instruction is squashed.
- RUN, priority 2 — LoadHit:
  - Outputs: PCWrite=0, IFIDWrite=0, IDEXFlush=1, IFIDFlush=0.
  - If LOAD_STALL_CYCLES>1: next state STALL, cnt<=LOAD_STALL_CYCLES-1. Otherwise stay in RUN.
- STALL:
  - Outputs: PCWrite=0, IFIDWrite=0, IDEXFlush=1.
  - cnt decrements each cycle; when cnt==1 the next state is RUN.
  - LoadHit is not re-evaluated in STALL, since ID/EX holds a bubble.
  - Redirect in STALL (defensive) aborts the stall: apply the redirect outputs and return to RUN with cnt<=0.
- Outputs are combinational from state and inputs, with zero-cycle latency relative to the hazard. State and cnt are registered.
- Total bubbles per LoadHit = exactly LOAD_STALL_CYCLES.
- The ID instruction re-evaluates LoadHit on the cycle after the stall ends; because the load has left EX, no duplicate stall occurs.
- Reset low (asynchronous, any cycle, including mid-STALL):
  - State=RUN, cnt=0.
  - While Reset is low: PCWrite=0, IFIDWrite=0, IFIDFlush=1, IDEXFlush=1.
  - First cycle after release: normal RUN outputs.
- DestEX==0 never stalls.
- Unknown or X on MemReadEX while RegWriteEX=0 must not stall.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined:
  - StallCount increments once per cycle with PCWrite=0 while Reset is high.
  - FlushCount increments once per cycle with Redirect=1.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: both ports and all counter logic are absent; stall/flush behaviour is identical.

Test Plan:
- Load-use, LOAD_STALL_CYCLES=1:
  - Stimulus: MemReadEX=2'b01, RegWriteEX=1, RegDstEX=0, RegDst1EX=5'd8, RsID=5'd8.
  - Response: that cycle PCWrite=0, IFIDWrite=0, IDEXFlush=1; next cycle (EX bubble) all defaults.
- Load-use, LOAD_STALL_CYCLES=2:
  - Stimulus: same as above, with RtID=8, UsesRtID=1, RsID=3.
  - Response: PCWrite=0 for exactly 2 consecutive cycles, then 1.
- No hazard:
  - Stimulus: DestEX=0 with RsID=0 → no stall. Then DestEX=9, RtID=9, UsesRtID=0, RsID=4 → no stall.
  - Response: PCWrite=1 throughout.
- Redirect priority:
  - Stimulus: BranchTakenEX=1 and LoadHit true in the same cycle.
  - Response: IFIDFlush=1, IDEXFlush=1, PCWrite=1; next cycle no stall. With HAZARD_STATS_EN: FlushCount=1, StallCount=0.
- Reset mid-stall:
  - Stimulus: LOAD_STALL_CYCLES=3; assert Reset=0 asynchronously in the 2nd stall cycle; release.
  - Response: outputs go immediately to PCWrite=0/IFIDFlush=1/IDEXFlush=1; after release, RUN defaults with no residual stall.
- Jr redirect:
  - Stimulus: JrEX=1 in RUN for one cycle.
  - Response: IFIDFlush=1 and IDEXFlush=1 for that single cycle only.

Source files
------------

// File: rtl/hazard_control.sv
// Load-use stall / branch-Jr flush control for the 5-stage pipeline.
// Optional statistics counters are compiled in with `define HAZARD_STATS_EN.
module hazard_control #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [1:0]       MemReadEX,
    input  logic             RegWriteEX,
    input  logic             RegDstEX,
    input  logic [4:0]       RegDst1EX,
    input  logic [4:0]       RegDst2EX,
    input  logic [4:0]       RsID,
    input  logic [4:0]       RtID,
    input  logic             UsesRtID,
    input  logic             BranchTakenEX,
    input  logic             JrEX,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             IDEXFlush
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
`endif
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    localparam logic       MULTI_STALL = (LOAD_STALL_CYCLES > 1);
    localparam logic [2:0] CNT_INIT    = 3'(LOAD_STALL_CYCLES - 1);

    state_t     state_r;
    logic [2:0] cnt_r;
    logic [4:0] dest_s;
    logic       load_hit_s;
    logic       redirect_s;

    // Hazard detection against the EX-stage destination register.
    always_comb begin
        dest_s     = RegDstEX ? RegDst2EX : RegDst1EX;
        // RegWriteEX gates first so an unknown MemReadEX on a non-writing op cannot stall.
        load_hit_s = RegWriteEX & (MemReadEX != 2'b00) & (dest_s != 5'd0) &
                     ((dest_s == RsID) | (UsesRtID & (dest_s == RtID)));
        redirect_s = BranchTakenEX | JrEX;
    end

    // Pipeline control outputs, zero-latency from state and inputs.
    always_comb begin
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
        IFIDFlush = 1'b0;
        IDEXFlush = 1'b0;
        if (!Reset) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
        end else if (redirect_s) begin
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
        end else if ((state_r == ST_STALL) || load_hit_s) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
        end else begin
            PCWrite   = 1'b1;
        end
    end

    // Stall sequencer: RUN/STALL with a down-counter of remaining bubbles.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r <= ST_RUN;
            cnt_r   <= 3'd0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (redirect_s) begin
                        state_r <= ST_RUN;
                        cnt_r   <= 3'd0;
                    end else if (load_hit_s && MULTI_STALL) begin
                        state_r <= ST_STALL;
                        cnt_r   <= CNT_INIT;
                    end else begin
                        state_r <= ST_RUN;
                        cnt_r   <= 3'd0;
                    end
                end
                ST_STALL: begin
                    if (redirect_s || (cnt_r <= 3'd1)) begin
                        state_r <= ST_RUN;
                        cnt_r   <= 3'd0;
                    end else begin
                        state_r <= ST_STALL;
                        cnt_r   <= cnt_r - 3'd1;
                    end
                end
                default: begin
                    state_r <= ST_RUN;
                    cnt_r   <= 3'd0;
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    // Saturating stall-cycle and redirect-event counters.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (!PCWrite && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (redirect_s && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_W'(1);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign StallCount = stall_cnt_r;
    assign FlushCount = flush_cnt_r;
`endif

endmodule

// File: tb/tb_hazard_control.sv
// Scoreboard bench: three instances (1, 2 and 3 load-stall cycles) share one stimulus stream.
module tb_hazard_control;

    logic       Clk;
    logic       Reset;
    logic [1:0] MemReadEX;
    logic       RegWriteEX, RegDstEX, UsesRtID, BranchTakenEX, JrEX;
    logic [4:0] RegDst1EX, RegDst2EX, RsID, RtID;
    logic [3:0] o1, o2, o3;   // {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush}
`ifdef HAZARD_STATS_EN
    logic [31:0] sc1, sc2, sc3, fc1, fc2, fc3;
`endif

    localparam logic [3:0] RN = 4'b1100;  // run
    localparam logic [3:0] SL = 4'b0001;  // stall
    localparam logic [3:0] FL = 4'b1111;  // redirect flush
    localparam logic [3:0] RZ = 4'b0011;  // in reset

    hazard_control #(.LOAD_STALL_CYCLES(1)) u1 (
        .Clk(Clk), .Reset(Reset), .MemReadEX(MemReadEX), .RegWriteEX(RegWriteEX),
        .RegDstEX(RegDstEX), .RegDst1EX(RegDst1EX), .RegDst2EX(RegDst2EX), .RsID(RsID),
        .RtID(RtID), .UsesRtID(UsesRtID), .BranchTakenEX(BranchTakenEX), .JrEX(JrEX),
        .PCWrite(o1[3]), .IFIDWrite(o1[2]), .IFIDFlush(o1[1]), .IDEXFlush(o1[0])
`ifdef HAZARD_STATS_EN
        , .StallCount(sc1), .FlushCount(fc1)
`endif
    );
    hazard_control #(.LOAD_STALL_CYCLES(2)) u2 (
        .Clk(Clk), .Reset(Reset), .MemReadEX(MemReadEX), .RegWriteEX(RegWriteEX),
        .RegDstEX(RegDstEX), .RegDst1EX(RegDst1EX), .RegDst2EX(RegDst2EX), .RsID(RsID),
        .RtID(RtID), .UsesRtID(UsesRtID), .BranchTakenEX(BranchTakenEX), .JrEX(JrEX),
        .PCWrite(o2[3]), .IFIDWrite(o2[2]), .IFIDFlush(o2[1]), .IDEXFlush(o2[0])
`ifdef HAZARD_STATS_EN
        , .StallCount(sc2), .FlushCount(fc2)
`endif
    );
    hazard_control #(.LOAD_STALL_CYCLES(3)) u3 (
        .Clk(Clk), .Reset(Reset), .MemReadEX(MemReadEX), .RegWriteEX(RegWriteEX),
        .RegDstEX(RegDstEX), .RegDst1EX(RegDst1EX), .RegDst2EX(RegDst2EX), .RsID(RsID),
        .RtID(RtID), .UsesRtID(UsesRtID), .BranchTakenEX(BranchTakenEX), .JrEX(JrEX),
        .PCWrite(o3[3]), .IFIDWrite(o3[2]), .IFIDFlush(o3[1]), .IDEXFlush(o3[0])
`ifdef HAZARD_STATS_EN
        , .StallCount(sc3), .FlushCount(fc3)
`endif
    );

    typedef struct {
        string      name;
        logic       rst;
        logic       rdr;
        logic [3:0] e1, e2, e3;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   st_model[3] = '{0, 0, 0};
    int   fl_model[3] = '{0, 0, 0};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic cmp(input string nm, input int inst, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s u%0d got %b want %b", nm, inst, got, want);
        end
    endtask

    // Monitor: sample mid-cycle and compare against the oldest expectation.
    always @(negedge Clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            cmp(e.name, 1, o1, e.e1);
            cmp(e.name, 2, o2, e.e2);
            cmp(e.name, 3, o3, e.e3);
            if (!e.rst) begin
                st_model = '{0, 0, 0};
                fl_model = '{0, 0, 0};
            end else begin
                if (!e.e1[3]) st_model[0]++;
                if (!e.e2[3]) st_model[1]++;
                if (!e.e3[3]) st_model[2]++;
                if (e.rdr) fl_model = '{fl_model[0] + 1, fl_model[1] + 1, fl_model[2] + 1};
            end
        end
    end

    task automatic drive(input string nm, input logic rst, input logic [1:0] mr, input logic rw,
                         input logic rd, input logic [4:0] d1, input logic [4:0] d2,
                         input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                         input logic bt, input logic jr,
                         input logic [3:0] e1, input logic [3:0] e2, input logic [3:0] e3);
        exp_t e;
        @(posedge Clk);
        #1;
        Reset = rst; MemReadEX = mr; RegWriteEX = rw; RegDstEX = rd; RegDst1EX = d1;
        RegDst2EX = d2; RsID = rs; RtID = rt; UsesRtID = urt; BranchTakenEX = bt; JrEX = jr;
        e.name = nm; e.rst = rst; e.rdr = bt | jr; e.e1 = e1; e.e2 = e2; e.e3 = e3;
        sb_q.push_back(e);
    endtask

    task automatic idle(input string nm, input logic [3:0] e1, input logic [3:0] e2, input logic [3:0] e3);
        drive(nm, 1'b1, 2'b00, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, e1, e2, e3);
    endtask

    task automatic hazard_rs(input string nm);
        drive(nm, 1'b1, 2'b01, 1'b1, 1'b0, 5'd8, 5'd0, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, SL, SL, SL);
    endtask

    initial begin
        Reset = 1'b0; MemReadEX = 2'b00; RegWriteEX = 1'b0; RegDstEX = 1'b0;
        RegDst1EX = 5'd0; RegDst2EX = 5'd0; RsID = 5'd0; RtID = 5'd0;
        UsesRtID = 1'b0; BranchTakenEX = 1'b0; JrEX = 1'b0;

        drive("rst_hold", 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, RZ, RZ, RZ);
        idle("rst_rel", RN, RN, RN);

        // load-use via rs: 1, 2 and 3 bubbles respectively
        hazard_rs("lu_rs");
        idle("lu_bub1", RN, SL, SL);
        idle("lu_bub2", RN, RN, SL);
        idle("lu_done", RN, RN, RN);

        // async reset during u3's second stall cycle
        hazard_rs("rst_mid_hit");
        drive("rst_mid_lo", 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, RZ, RZ, RZ);
        drive("rst_mid_lo2", 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, RZ, RZ, RZ);
        idle("rst_mid_rel", RN, RN, RN);
        idle("rst_mid_after", RN, RN, RN);

        // load-use via rt
        drive("lu_rt", 1'b1, 2'b01, 1'b1, 1'b0, 5'd8, 5'd0, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0, SL, SL, SL);
        idle("lu_rt_bub1", RN, SL, SL);
        idle("lu_rt_bub2", RN, RN, SL);
        idle("lu_rt_done", RN, RN, RN);

        // no-hazard cases
        drive("dest0", 1'b1, 2'b01, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, RN, RN, RN);
        drive("rt_unused", 1'b1, 2'b01, 1'b1, 1'b1, 5'd7, 5'd9, 5'd4, 5'd9, 1'b0, 1'b0, 1'b0, RN, RN, RN);
        drive("rs_vs_rt_field", 1'b1, 2'b10, 1'b1, 1'b1, 5'd9, 5'd7, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, RN, RN, RN);
        drive("nowrite_x", 1'b1, 2'bxx, 1'b0, 1'b0, 5'd8, 5'd0, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, RN, RN, RN);
        drive("nowrite_ld", 1'b1, 2'b11, 1'b0, 1'b0, 5'd8, 5'd0, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, RN, RN, RN);

        // rd destination hits rt when rt is used
        drive("rd_rt_hit", 1'b1, 2'b01, 1'b1, 1'b1, 5'd7, 5'd9, 5'd4, 5'd9, 1'b1, 1'b0, 1'b0, SL, SL, SL);
        idle("rd_rt_bub1", RN, SL, SL);
        idle("rd_rt_bub2", RN, RN, SL);
        idle("rd_rt_done", RN, RN, RN);

        // redirect beats a simultaneous load-use
        drive("redir_pri", 1'b1, 2'b01, 1'b1, 1'b0, 5'd8, 5'd0, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0, FL, FL, FL);
        idle("redir_after", RN, RN, RN);

        // Jr redirect is a single-cycle flush
        drive("jr", 1'b1, 2'b00, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, FL, FL, FL);
        idle("jr_after", RN, RN, RN);

        // redirect while stalling aborts the stall
        hazard_rs("abort_hit");
        drive("abort_br", 1'b1, 2'b00, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, FL, FL, FL);
        idle("abort_after", RN, RN, RN);
        idle("end_idle", RN, RN, RN);

        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", sb_q.size());
        end
`ifdef HAZARD_STATS_EN
        checks += 6;
        if (sc1 !== 32'(st_model[0])) begin errors++; $display("FAIL stall_cnt u1 got %0d want %0d", sc1, st_model[0]); end
        if (sc2 !== 32'(st_model[1])) begin errors++; $display("FAIL stall_cnt u2 got %0d want %0d", sc2, st_model[1]); end
        if (sc3 !== 32'(st_model[2])) begin errors++; $display("FAIL stall_cnt u3 got %0d want %0d", sc3, st_model[2]); end
        if (fc1 !== 32'(fl_model[0])) begin errors++; $display("FAIL flush_cnt u1 got %0d want %0d", fc1, fl_model[0]); end
        if (fc2 !== 32'(fl_model[1])) begin errors++; $display("FAIL flush_cnt u2 got %0d want %0d", fc2, fl_model[1]); end
        if (fc3 !== 32'(fl_model[2])) begin errors++; $display("FAIL flush_cnt u3 got %0d want %0d", fc3, fl_model[2]); end
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
